fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage of the 16-bit pipelined MIPS-like core; sits directly upstream of the instruction memory and drives its byte address.
- Holds the program counter and presents it combinationally on iaddr.
- Captures the returned 16-bit instruction word into the IF/ID pipeline register for decode.
- Handles stall from hazard logic and PC redirects from branch resolution. A redirect flushes the fetched word as a bubble.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset; bit 0 ignored (forced 0).

Ports:
clock  input  1  single system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
iaddr  output  16  instruction byte address to instruction memory; always equals pc.
idata  input  16  instruction word returned combinationally for iaddr in the same cycle.
stall  input  1  hazard hold: freeze pc and IF/ID contents.
redirect  input  1  branch resolved taken, or mispredict: load redirect_pc.
redirect_pc  input  16  new fetch address; bit 0 forced 0.
ifid_instr  output  16  registered instruction to decode.
ifid_pc2  output  16  registered address of that instruction + 2, used as branch base.
ifid_valid  output  1  1 = ifid_instr is a real instruction; 0 = bubble.
ifid_pred_taken  output  1  fetch predicted this instruction as a taken branch. Constant 0 unless the optional feature is enabled.

Behaviour:
- State: pc[15:0] (bit 0 always 0), ifid_instr, ifid_pc2, ifid_valid, ifid_pred_taken. All registered on the rising clock edge, cleared asynchronously.
- Reset (reset=0, any time, including mid-stall or mid-redirect):
  - pc=RESET_PC & 16'hFFFE; ifid_instr=0; ifid_pc2=0; ifid_valid=0; ifid_pred_taken=0.
  - Effect is immediate and asynchronous. The first edge after release fetches from RESET_PC.
- iaddr = pc, combinational, no added latency. Fetch-to-decode latency is 1 clock: the word at iaddr in cycle N appears on ifid_instr after edge N.
- Next-state priority each edge: redirect > stall > normal.
  - redirect=1:
    - pc <= redirect_pc & 16'hFFFE.
    - IF/ID becomes a bubble: ifid_valid<=0, ifid_instr<=0, ifid_pc2<=0, ifid_pred_taken<=0.
    - Overrides a simultaneous stall.
  - stall=1, redirect=0: pc and all ifid_* hold their values. No iaddr change.
  - normal:
    - pc <= next_pc (pc+2 modulo 2^16; wraps 16'hFFFE -> 16'h0000 silently).
    - ifid_instr<=idata; ifid_pc2<=pc+2; ifid_valid<=1; ifid_pred_taken<=predict.
- Instruction word 0 is still valid=1 (it is a nop); only flushes/reset produce valid=0.
- No internal FSM beyond the register set. Two operating conditions: RUN (advancing) and HOLD (stall). Redirect is a single-cycle event from either.
- Arithmetic is 16-bit unsigned with wrap-around; no overflow flag.

Optional Feature:
Macro FETCH_BTFN_PREDICT_EN enables static backward-taken/forward-not-taken prediction.
- With the macro defined, a branch is predicted when all of the following hold:
  - idata[15:13]==3'd2 (beq);
  - idata[6]==1 (negative offset);
  - the cycle is normal (no stall, no redirect).
- On a predicted branch:
  - next_pc = pc + 2 + (sign_extend(idata[6:0]) << 1), 16-bit wrap;
  - ifid_pred_taken<=1.
- Downstream issues redirect on mispredict; redirect still has top priority.
- Without the macro: next_pc = pc+2 always, ifid_pred_taken tied to 0, and no opcode decode logic is present.

Test Plan:
1. Reset release, no stall/redirect, memory returns the program (index i at address 2i) -> iaddr steps 0,2,4,6; after edge 1: ifid_instr=16'h6103, ifid_pc2=2, ifid_valid=1.
2. Assert reset=0 asynchronously mid-cycle at pc=8 -> iaddr=0 and ifid_valid=0 immediately, without waiting for a clock edge.
3. At pc=6, stall=1 for 3 clocks -> iaddr holds 6 and ifid_* hold the pc=4 fetch; on release, the next edge captures the pc=6 word with ifid_pc2=8.
4. At pc=10, redirect=1, redirect_pc=16'h0005 -> next iaddr=4, ifid_valid=0 for one cycle, then valid fetch from 4. Repeat with stall=1 simultaneously -> same result (redirect wins).
5. Set pc=16'hFFFE via redirect -> fetch there with ifid_pc2=0; the following iaddr=0 (wrap).
6. FETCH_BTFN_PREDICT_EN defined, beq 0,0,-9 (16'h4077) fetched at pc=16 -> next iaddr=0, ifid_pred_taken=1. A forward beq with offset +3 -> next iaddr=pc+2, ifid_pred_taken=0. With the macro undefined -> iaddr=18 and pred=0 in both cases.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: program counter, IF/ID pipeline register, stall/redirect handling.
// Optional static backward-taken/forward-not-taken prediction enabled by FETCH_BTFN_PREDICT_EN.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] iaddr,
  input  logic [15:0] idata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc2,
  output logic        ifid_valid,
  output logic        ifid_pred_taken
);

  localparam logic [15:0] PC_INIT = RESET_PC & 16'hFFFE;

  logic [15:0] pc_q, pc_d;
  logic [15:0] ifid_instr_q, ifid_instr_d;
  logic [15:0] ifid_pc2_q, ifid_pc2_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        ifid_pred_taken_q, ifid_pred_taken_d;

  logic [15:0] pc_plus2;
  logic [15:0] next_pc;
  logic        predict;

  assign pc_plus2 = pc_q + 16'd2;

`ifdef FETCH_BTFN_PREDICT_EN
  logic [15:0] branch_target;

  // Backward beq (negative 7-bit word offset) is assumed taken.
  always_comb begin
    predict       = (idata[15:13] == 3'd2) && idata[6];
    branch_target = pc_plus2 + {{8{idata[6]}}, idata[6:0], 1'b0};
    next_pc       = predict ? branch_target : pc_plus2;
  end
`else
  always_comb begin
    predict = 1'b0;
    next_pc = pc_plus2;
  end
`endif

  // Priority: redirect flushes to a bubble, stall holds everything, otherwise advance.
  always_comb begin
    pc_d              = pc_q;
    ifid_instr_d      = ifid_instr_q;
    ifid_pc2_d        = ifid_pc2_q;
    ifid_valid_d      = ifid_valid_q;
    ifid_pred_taken_d = ifid_pred_taken_q;
    if (redirect) begin
      pc_d              = redirect_pc & 16'hFFFE;
      ifid_instr_d      = 16'h0000;
      ifid_pc2_d        = 16'h0000;
      ifid_valid_d      = 1'b0;
      ifid_pred_taken_d = 1'b0;
    end else if (!stall) begin
      pc_d              = next_pc;
      ifid_instr_d      = idata;
      ifid_pc2_d        = pc_plus2;
      ifid_valid_d      = 1'b1;
      ifid_pred_taken_d = predict;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q              <= PC_INIT;
      ifid_instr_q      <= 16'h0000;
      ifid_pc2_q        <= 16'h0000;
      ifid_valid_q      <= 1'b0;
      ifid_pred_taken_q <= 1'b0;
    end else begin
      pc_q              <= pc_d;
      ifid_instr_q      <= ifid_instr_d;
      ifid_pc2_q        <= ifid_pc2_d;
      ifid_valid_q      <= ifid_valid_d;
      ifid_pred_taken_q <= ifid_pred_taken_d;
    end
  end

  assign iaddr           = pc_q;
  assign ifid_instr      = ifid_instr_q;
  assign ifid_pc2        = ifid_pc2_q;
  assign ifid_valid      = ifid_valid_q;
  assign ifid_pred_taken = ifid_pred_taken_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized stall/redirect traffic against a
// behavioural fetch model driven by a small instruction memory.
module tb_fetch_unit;

  logic        clock;
  logic        reset;
  logic [15:0] iaddr;
  logic [15:0] idata;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc2;
  logic        ifid_valid;
  logic        ifid_pred_taken;

  int n_cmp;
  int n_bad;

  logic [15:0] mem [0:255];

  // reference model state
  logic [15:0] pc_m, instr_m, pc2_m;
  logic        valid_m, pred_m;

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clock          (clock),
    .reset          (reset),
    .iaddr          (iaddr),
    .idata          (idata),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .ifid_instr     (ifid_instr),
    .ifid_pc2       (ifid_pc2),
    .ifid_valid     (ifid_valid),
    .ifid_pred_taken(ifid_pred_taken)
  );

  assign idata = mem[iaddr[8:1]];

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic model_reset();
    pc_m = 16'h0000; instr_m = 16'h0000; pc2_m = 16'h0000; valid_m = 1'b0; pred_m = 1'b0;
  endtask

  // Advance the model by one clock using the current inputs, then move past the DUT edge.
  task automatic step();
    logic [15:0] w;
    int          off;
    bit          pred;
    w = mem[pc_m[8:1]];
    if (redirect) begin
      pc_m = redirect_pc & 16'hFFFE;
      instr_m = 16'h0000; pc2_m = 16'h0000; valid_m = 1'b0; pred_m = 1'b0;
    end else if (!stall) begin
      pred = 1'b0;
`ifdef FETCH_BTFN_PREDICT_EN
      pred = (w[15:13] == 3'd2) && w[6];
`endif
      off = int'(w[6:0]);
      if (w[6]) off = off - 128;
      instr_m = w;
      pc2_m   = pc_m + 16'd2;
      valid_m = 1'b1;
      pred_m  = pred;
      pc_m    = pred ? 16'(int'(pc_m) + 2 + 2 * off) : 16'(pc_m + 16'd2);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    n_cmp++;
    if ({iaddr, ifid_instr, ifid_pc2, ifid_valid, ifid_pred_taken} !== 50'd0) begin
      n_bad++;
      $display("FAIL reset_state: got iaddr=%h instr=%h pc2=%h v=%b p=%b, want all zero",
               iaddr, ifid_instr, ifid_pc2, ifid_valid, ifid_pred_taken);
    end
    reset = 1'b1;
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 4; i++) begin
      step();
      n_cmp++;
      if (iaddr !== 16'(2 * i)) begin
        n_bad++;
        $display("FAIL seq_iaddr[%0d]: got %h want %h", i, iaddr, 16'(2 * i));
      end
      if (i == 1) begin
        n_cmp++;
        if (ifid_instr !== 16'h6103 || ifid_pc2 !== 16'd2 || ifid_valid !== 1'b1) begin
          n_bad++;
          $display("FAIL seq_first_fetch: got instr=%h pc2=%h v=%b want 6103/0002/1",
                   ifid_instr, ifid_pc2, ifid_valid);
        end
      end
      n_cmp++;
      if ({ifid_instr, ifid_pc2, ifid_valid, ifid_pred_taken} !== {instr_m, pc2_m, valid_m, pred_m}) begin
        n_bad++;
        $display("FAIL seq_ifid[%0d]: got %h/%h/%b/%b want %h/%h/%b/%b", i, ifid_instr, ifid_pc2,
                 ifid_valid, ifid_pred_taken, instr_m, pc2_m, valid_m, pred_m);
      end
    end
  endtask

  task automatic test_async_reset();
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (iaddr !== 16'h0000 || ifid_valid !== 1'b0 || ifid_instr !== 16'h0000) begin
      n_bad++;
      $display("FAIL async_reset: got iaddr=%h v=%b instr=%h want 0000/0/0000",
               iaddr, ifid_valid, ifid_instr);
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_stall();
    repeat (3) step();
    n_cmp++;
    if (iaddr !== 16'd6) begin
      n_bad++;
      $display("FAIL stall_setup: got iaddr=%h want 0006", iaddr);
    end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (iaddr !== 16'd6 || ifid_pc2 !== 16'd6 || ifid_instr !== mem[2] || ifid_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL stall_hold[%0d]: got iaddr=%h pc2=%h instr=%h v=%b want 0006/0006/%h/1",
                 i, iaddr, ifid_pc2, ifid_instr, ifid_valid, mem[2]);
      end
    end
    stall = 1'b0;
    step();
    n_cmp++;
    if (ifid_instr !== mem[3] || ifid_pc2 !== 16'd8 || iaddr !== pc_m) begin
      n_bad++;
      $display("FAIL stall_release: got instr=%h pc2=%h iaddr=%h want %h/0008/%h",
               ifid_instr, ifid_pc2, iaddr, mem[3], pc_m);
    end
  endtask

  task automatic test_redirect();
    for (int pass = 0; pass < 2; pass++) begin
      redirect = 1'b1; redirect_pc = 16'h000A; stall = 1'b0;
      step();
      redirect_pc = 16'h0005; stall = (pass == 1);
      step();
      redirect = 1'b0; stall = 1'b0;
      n_cmp++;
      if (iaddr !== 16'd4 || ifid_valid !== 1'b0 || ifid_instr !== 16'h0000 || ifid_pc2 !== 16'h0000) begin
        n_bad++;
        $display("FAIL redirect_bubble[%0d]: got iaddr=%h v=%b instr=%h pc2=%h want 0004/0/0000/0000",
                 pass, iaddr, ifid_valid, ifid_instr, ifid_pc2);
      end
      step();
      n_cmp++;
      if (ifid_valid !== 1'b1 || ifid_instr !== mem[2] || ifid_pc2 !== 16'd6) begin
        n_bad++;
        $display("FAIL redirect_refetch[%0d]: got v=%b instr=%h pc2=%h want 1/%h/0006",
                 pass, ifid_valid, ifid_instr, ifid_pc2, mem[2]);
      end
    end
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    step();
    redirect = 1'b0;
    n_cmp++;
    if (iaddr !== 16'hFFFE) begin
      n_bad++;
      $display("FAIL wrap_target: got iaddr=%h want fffe", iaddr);
    end
    step();
    n_cmp++;
    if (ifid_pc2 !== 16'h0000 || ifid_valid !== 1'b1 || ifid_instr !== mem[255] || iaddr !== pc_m) begin
      n_bad++;
      $display("FAIL wrap_fetch: got pc2=%h v=%b instr=%h iaddr=%h want 0000/1/%h/%h",
               ifid_pc2, ifid_valid, ifid_instr, iaddr, mem[255], pc_m);
    end
  endtask

  task automatic test_predict();
    logic [15:0] exp_addr;
    logic        exp_pred;
`ifdef FETCH_BTFN_PREDICT_EN
    exp_addr = 16'h0000; exp_pred = 1'b1;
`else
    exp_addr = 16'd18;   exp_pred = 1'b0;
`endif
    redirect = 1'b1; redirect_pc = 16'd16;
    step();
    redirect = 1'b0;
    step();
    n_cmp++;
    if (iaddr !== exp_addr || ifid_pred_taken !== exp_pred || ifid_instr !== 16'h4077) begin
      n_bad++;
      $display("FAIL predict_backward: got iaddr=%h pred=%b instr=%h want %h/%b/4077",
               iaddr, ifid_pred_taken, ifid_instr, exp_addr, exp_pred);
    end
    redirect = 1'b1; redirect_pc = 16'd20;
    step();
    redirect = 1'b0;
    step();
    n_cmp++;
    if (iaddr !== 16'd22 || ifid_pred_taken !== 1'b0 || ifid_instr !== 16'h4003) begin
      n_bad++;
      $display("FAIL predict_forward: got iaddr=%h pred=%b instr=%h want 0016/0/4003",
               iaddr, ifid_pred_taken, ifid_instr);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      stall       = ($urandom_range(0, 3) == 0);
      redirect    = ($urandom_range(0, 7) == 0);
      redirect_pc = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 3) == 0) redirect_pc[15:9] = 7'h00;
      step();
      n_cmp++;
      if ({iaddr, ifid_instr, ifid_pc2, ifid_valid, ifid_pred_taken} !==
          {pc_m, instr_m, pc2_m, valid_m, pred_m}) begin
        n_bad++;
        $display("FAIL random[%0d]: got %h/%h/%h/%b/%b want %h/%h/%h/%b/%b", i, iaddr, ifid_instr,
                 ifid_pc2, ifid_valid, ifid_pred_taken, pc_m, instr_m, pc2_m, valid_m, pred_m);
      end
    end
    stall = 1'b0; redirect = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[0]  = 16'h6103;
    mem[8]  = 16'h4077;
    mem[10] = 16'h4003;
    test_reset();
    test_sequential();
    test_async_reset();
    test_stall();
    test_redirect();
    test_wrap();
    test_predict();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
